// File: rtl/logger_cmd_parser_pkg.sv
// Shared types and ASCII constants for the logger command path.
// byte_t/state_t are shared with the UART receiver and the logger FSM.
package logger_cmd_parser_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        START = 2'd1,
        DUMP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam byte_t CMD_START  = 8'h53; // 'S'
    localparam byte_t CMD_STOP   = 8'h54; // 'T'
    localparam byte_t CMD_DUMP   = 8'h44; // 'D'
    localparam byte_t CMD_CLEAR  = 8'h43; // 'C'
    localparam byte_t CMD_CH_EN  = 8'h45; // 'E'
    localparam byte_t CMD_CH_DIS = 8'h58; // 'X'
    localparam byte_t CMD_PERIOD = 8'h50; // 'P'
    localparam byte_t ASCII_CR   = 8'h0D;
    localparam byte_t ASCII_LF   = 8'h0A;

endpackage

// File: rtl/logger_cmd_parser_hex_nibble_decode.sv
// Combinational ASCII hex digit decoder ('0'-'9', 'A'-'F', 'a'-'f').
module hex_nibble_decode
    import logger_cmd_parser_pkg::*;
(
    input  byte_t      code,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = '0;
        is_hex = 1'b0;
        if (code >= 8'h30 && code <= 8'h39) begin
            nibble = code[3:0];
            is_hex = 1'b1;
        end else if ((code >= 8'h41 && code <= 8'h46) ||
                     (code >= 8'h61 && code <= 8'h66)) begin
            // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
            nibble = code[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/logger_cmd_parser.sv
// Byte-stream command parser: S/T/D/C state commands, E/X channel
// enable/disable and P hex argument, with inter-byte timeout.
module logger_cmd_parser
    import logger_cmd_parser_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned ARG_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  byte_t                   rx_data,
    input  logic                    rx_valid,
    input  state_t                  logger_state,
    output state_t                  new_logger_state,
    output logic [NUM_CH-1:0]       ch_mask,
    output logic [4*ARG_DIGITS-1:0] arg_value,
    output logic                    arg_valid,
    output logic                    cmd_err,
    output logic                    busy
);

    localparam int unsigned AW = 4 * ARG_DIGITS;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned DW = $clog2(ARG_DIGITS + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(ARG_DIGITS - 1);

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_CH_EN,
        PS_CH_DIS,
        PS_ARG
    } parse_t;

    parse_t            state, next_state;
    logic [TW-1:0]     tmo_cnt;
    logic [DW-1:0]     digit_cnt;
    logic [AW-1:0]     shreg, shifted;
    logic [3:0]        nibble;
    logic              is_hex;
    logic              tmo_hit;
    logic              ch_ok;
    logic [NUM_CH-1:0] ch_sel;

    logic   cmd_hit, set_err, arg_done, arg_start, shift_en, ch_set, ch_clr;
    state_t cmd_state;

    hex_nibble_decode u_hex (
        .code   (rx_data),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign shifted = AW'({shreg, nibble});

    always_comb begin
        ch_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (32'(nibble) == i);
        end
        ch_ok = is_hex && (32'(nibble) < NUM_CH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_hit    = 1'b0;
        cmd_state  = logger_state;
        set_err    = 1'b0;
        arg_done   = 1'b0;
        arg_start  = 1'b0;
        shift_en   = 1'b0;
        ch_set     = 1'b0;
        ch_clr     = 1'b0;
        unique case (state)
            PS_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_START:  begin cmd_hit = 1'b1; cmd_state = START; end
                        CMD_STOP:   begin cmd_hit = 1'b1; cmd_state = STOP;  end
                        CMD_DUMP:   begin cmd_hit = 1'b1; cmd_state = DUMP;  end
                        CMD_CLEAR:  begin cmd_hit = 1'b1; cmd_state = CLEAR; end
                        CMD_CH_EN:  next_state = PS_CH_EN;
                        CMD_CH_DIS: next_state = PS_CH_DIS;
                        CMD_PERIOD: begin
                            next_state = PS_ARG;
                            arg_start  = 1'b1;
                        end
                        ASCII_CR, ASCII_LF: ;
                        default:    set_err = 1'b1;
                    endcase
                end
            end
            PS_CH_EN, PS_CH_DIS: begin
                if (rx_valid) begin
                    next_state = PS_IDLE;
                    if (!ch_ok) begin
                        set_err = 1'b1;
                    end else if (state == PS_CH_EN) begin
                        ch_set = 1'b1;
                    end else begin
                        ch_clr = 1'b1;
                    end
                end else if (tmo_hit) begin
                    next_state = PS_IDLE;
                    set_err    = 1'b1;
                end
            end
            PS_ARG: begin
                if (rx_valid) begin
                    if (!is_hex) begin
                        next_state = PS_IDLE;
                        set_err    = 1'b1;
                    end else begin
                        shift_en = 1'b1;
                        if (digit_cnt == LAST_DIGIT) begin
                            next_state = PS_IDLE;
                            arg_done   = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    next_state = PS_IDLE;
                    set_err    = 1'b1;
                end
            end
            default: next_state = PS_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != PS_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_logger_state <= STOP;
            ch_mask          <= '1;
            arg_value        <= '0;
            arg_valid        <= 1'b0;
            cmd_err          <= 1'b0;
            tmo_cnt          <= '0;
            digit_cnt        <= '0;
            shreg            <= '0;
        end else begin
            new_logger_state <= cmd_hit ? cmd_state : logger_state;
            cmd_err          <= set_err;
            arg_valid        <= arg_done;
            if (ch_set) begin
                ch_mask <= ch_mask | ch_sel;
            end else if (ch_clr) begin
                ch_mask <= ch_mask & ~ch_sel;
            end
            if (arg_start) begin
                shreg     <= '0;
                digit_cnt <= '0;
            end else if (shift_en) begin
                shreg     <= shifted;
                digit_cnt <= digit_cnt + 1'b1;
            end
            if (arg_done) begin
                arg_value <= shifted;
            end
            // Expiry and IDLE both park the counter at zero; a byte always restarts it.
            if (state == PS_IDLE || rx_valid || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logger_cmd_parser.sv
// Randomized and directed bench for logger_cmd_parser against a byte-level model.
module tb_logger_cmd_parser;
    import logger_cmd_parser_pkg::*;

    localparam int NCH = 4;
    localparam int NDIG = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    state_t      logger_state = STOP;
    state_t      new_logger_state;
    logic [NCH-1:0]    ch_mask;
    logic [4*NDIG-1:0] arg_value;
    logic        arg_valid, cmd_err, busy;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 enable, 2 disable, 3 collecting argument.
    int        m_mode = 0;
    int        m_digits[$];
    int        m_idle = 0;
    state_t    m_nls = STOP;
    logic [3:0]  m_mask = '1;
    logic [15:0] m_arg = '0;
    bit        m_err = 0, m_av = 0;
    state_t    ls_drv = STOP;

    logger_cmd_parser #(
        .NUM_CH(NCH),
        .ARG_DIGITS(NDIG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .logger_state(logger_state),
        .new_logger_state(new_logger_state),
        .ch_mask(ch_mask),
        .arg_value(arg_value),
        .arg_valid(arg_valid),
        .cmd_err(cmd_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input state_t ls);
        int h;
        int acc;
        m_err = 0;
        m_av  = 0;
        m_nls = ls;
        if (r) begin
            m_mode = 0; m_digits.delete(); m_idle = 0;
            m_nls = STOP; m_mask = '1; m_arg = '0;
            return;
        end
        h = hexval(d);
        if (m_mode == 0) begin
            if (v) begin
                case (d)
                    "S": m_nls = START;
                    "T": m_nls = STOP;
                    "D": m_nls = DUMP;
                    "C": m_nls = CLEAR;
                    "E": begin m_mode = 1; m_idle = 0; end
                    "X": begin m_mode = 2; m_idle = 0; end
                    "P": begin m_mode = 3; m_idle = 0; m_digits.delete(); end
                    8'h0D, 8'h0A: ;
                    default: m_err = 1;
                endcase
            end
        end else if (!v) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1; m_mode = 0; m_digits.delete();
            end
        end else begin
            m_idle = 0;
            if (m_mode == 3) begin
                if (h < 0) begin
                    m_err = 1; m_mode = 0; m_digits.delete();
                end else begin
                    m_digits.push_back(h);
                    if (m_digits.size() == NDIG) begin
                        acc = 0;
                        foreach (m_digits[i]) acc = acc * 16 + m_digits[i];
                        m_arg = 16'(acc); m_av = 1; m_mode = 0; m_digits.delete();
                    end
                end
            end else begin
                if (h < 0 || h >= NCH) m_err = 1;
                else if (m_mode == 1) m_mask[h] = 1'b1;
                else m_mask[h] = 1'b0;
                m_mode = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d);
        @(negedge clk);
        rst = r; rx_valid = v; rx_data = d; logger_state = ls_drv;
        @(posedge clk);
        model_step(r, v, d, ls_drv);
        #1;
        check_eq("nls",  32'(new_logger_state), 32'(m_nls));
        check_eq("mask", 32'(ch_mask), 32'(m_mask));
        check_eq("arg",  32'(arg_value), 32'(m_arg));
        check_eq("argv", 32'(arg_valid), 32'(m_av));
        check_eq("err",  32'(cmd_err), 32'(m_err));
        check_eq("busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cyc(0, 1, s[i]);
    endtask

    initial begin
        string cmds = "STDCEXP";
        string hexs = "0123456789abcdefABCDEF";
        int sel;

        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        check_eq("rst_mask", 32'(ch_mask), 32'hF);
        check_eq("rst_nls", 32'(new_logger_state), 32'(STOP));

        ls_drv = STOP;
        cyc(0, 1, 8'h53);
        check_eq("s_start", 32'(new_logger_state), 32'(START));
        cyc(0, 1, 8'h41);
        check_eq("bad_err", 32'(cmd_err), 32'd1);
        check_eq("bad_nls", 32'(new_logger_state), 32'(STOP));

        send_str("X2");
        check_eq("x2_mask", 32'(ch_mask), 32'hB);
        send_str("E2");
        check_eq("e2_mask", 32'(ch_mask), 32'hF);
        send_str("E7");
        check_eq("e7_err", 32'(cmd_err), 32'd1);
        check_eq("e7_mask", 32'(ch_mask), 32'hF);

        send_str("P1a3F");
        check_eq("p_arg", 32'(arg_value), 32'h1A3F);
        check_eq("p_argv", 32'(arg_valid), 32'd1);
        cyc(0, 0, 8'h00);
        check_eq("p_argv_drop", 32'(arg_valid), 32'd0);

        send_str("P12S");
        check_eq("abort_err", 32'(cmd_err), 32'd1);
        check_eq("abort_nls", 32'(new_logger_state), 32'(STOP));
        check_eq("abort_arg", 32'(arg_value), 32'h1A3F);
        send_str("S");
        check_eq("abort_s", 32'(new_logger_state), 32'(START));

        send_str("P");
        for (int k = 1; k <= TMO; k++) begin
            cyc(0, 0, 8'h00);
            if (k == TMO) check_eq("tmo_err", 32'(cmd_err), 32'd1);
            else check_eq("tmo_quiet", 32'(cmd_err), 32'd0);
        end
        check_eq("tmo_idle", 32'(busy), 32'd0);

        send_str("P");
        for (int k = 1; k < TMO; k++) cyc(0, 0, 8'h00);
        cyc(0, 1, "1");
        check_eq("tmo_win_err", 32'(cmd_err), 32'd0);
        check_eq("tmo_win_busy", 32'(busy), 32'd1);
        send_str("234");
        check_eq("tmo_win_arg", 32'(arg_value), 32'h1234);

        send_str("X0P1A");
        cyc(1, 0, 8'h00);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_mask", 32'(ch_mask), 32'hF);
        check_eq("mid_rst_nls", 32'(new_logger_state), 32'(STOP));
        send_str("P0001");
        check_eq("post_rst_arg", 32'(arg_value), 32'h0001);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) ls_drv = state_t'($urandom_range(0, 3));
            sel = $urandom_range(0, 11);
            if ($urandom_range(0, 299) == 0) cyc(1, 0, 8'h00);
            else if (sel <= 1) cyc(0, 1, cmds[$urandom_range(0, 6)]);
            else if (sel == 2) cyc(0, 1, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
            else if (sel <= 6) cyc(0, 1, hexs[$urandom_range(0, 21)]);
            else if (sel == 7) cyc(0, 1, 8'($urandom));
            else if (sel == 8) begin
                for (int g = $urandom_range(0, TMO + 2); g > 0; g--) cyc(0, 0, 8'($urandom));
            end else cyc(0, 0, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
